// File: rtl/rvp_pkg.sv
// rvp_pkg: shared types and constants for the riscv_pipeline fetch stage.
//   XLEN          - address/data width
//   NOP_INSTR     - addi x0,x0,0, placed in IF/ID on bubbles
//   fetch_state_t - fetch FSM state encoding (BOOT, RUN, HOLD, HALT)
//   if_id_t       - IF/ID pipeline register contents
//   make_if_id()  - IF/ID value constructor; if_id_bubble() - empty slot
package rvp_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t BOOT = 2'd0;
    localparam fetch_state_t RUN  = 2'd1;
    localparam fetch_state_t HOLD = 2'd2;
    localparam fetch_state_t HALT = 2'd3;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            misalign;
    } if_id_t;

    function automatic if_id_t make_if_id(input logic            valid,
                                          input logic [XLEN-1:0] pc,
                                          input logic [XLEN-1:0] instr,
                                          input logic            misalign);
        if_id_t r;
        r.valid    = valid;
        r.pc       = pc;
        r.instr    = instr;
        r.misalign = misalign;
        return r;
    endfunction

    function automatic if_id_t if_id_bubble();
        return make_if_id(1'b0, '0, NOP_INSTR, 1'b0);
    endfunction

endpackage

// File: rtl/rvp_fetch_skid.sv
// rvp_fetch_skid: one-entry skid buffer holding an instruction (pc + word) that
// returned from imem while the fetch stage was stalled.
//   clk_i, rst_ni      - clock, asynchronous active-low reset
//   push_i             - capture pc_i/instr_i
//   pop_i              - release the held entry
//   flush_i            - discard the held entry (wins over push/pop)
//   full_o             - entry valid
//   pc_o, instr_o      - held entry
module rvp_fetch_skid
    import rvp_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] instr_i,
    output logic            full_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] instr_o
);

    logic            full_q, full_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;

    always_comb begin
        full_d  = full_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (flush_i) begin
            full_d = 1'b0;
        end else if (push_i) begin
            full_d  = 1'b1;
            pc_d    = pc_i;
            instr_d = instr_i;
        end else if (pop_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q  <= 1'b0;
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
        end else begin
            full_q  <= full_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign full_o  = full_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/riscv_fetch_stage.sv
// riscv_fetch_stage: instruction fetch for the 5-stage riscv_pipeline. Owns the PC,
// drives a synchronous imem (1-cycle read latency) and fills the IF/ID register.
//   clk, reset            - clock, asynchronous active-low reset
//   pc_init               - boot PC, sampled while reset is low
//   stall                 - hold IF/ID and PC
//   redirect_e/redirect_pc- branch/jump redirect from execute (beats stall)
//   imem_addr/imem_rdata  - fetch address / data for previous cycle's address
//   if_valid/if_pc/if_instr/if_misalign - IF/ID contents
// Build option: define RVP_FETCH_MISALIGN_EN to fault on redirect targets with
// pc[1:0] != 0 (halt fetch until the next redirect); otherwise the low bits are dropped.
module riscv_fetch_stage
    import rvp_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_init,
    input  logic            stall,
    input  logic            redirect_e,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    output logic            if_misalign
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            resp_valid_q, resp_valid_d;  // imem_rdata belongs to a live fetch
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    if_id_t          ifid_q, ifid_d;

    logic            skid_push, skid_pop, skid_flush, skid_full;
    logic [XLEN-1:0] skid_pc, skid_instr;

    logic [XLEN-1:0] tgt;
    logic            tgt_mis;

`ifdef RVP_FETCH_MISALIGN_EN
    assign tgt     = redirect_pc;
    assign tgt_mis = |redirect_pc[1:0];
`else
    assign tgt     = redirect_pc & ~XLEN'(3);
    assign tgt_mis = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        resp_valid_d = 1'b0;
        resp_pc_d    = resp_pc_q;
        ifid_d       = ifid_q;
        skid_push    = 1'b0;
        skid_pop     = 1'b0;
        skid_flush   = 1'b0;

        if (redirect_e) begin
            // Squash whatever is in flight or parked; the target is fetched next cycle.
            pc_d       = tgt;
            skid_flush = 1'b1;
            if (tgt_mis) begin
                state_d = HALT;
                ifid_d  = make_if_id(1'b1, tgt, NOP_INSTR, 1'b1);
            end else begin
                state_d = RUN;
                ifid_d  = if_id_bubble();
            end
        end else if (state_q == HALT) begin
            // Fault report stays in IF/ID and no fetch is issued until a redirect.
        end else if (stall) begin
            // No new fetch while stalled, so at most one response ever needs parking.
            state_d   = HOLD;
            skid_push = resp_valid_q;
        end else begin
            state_d = RUN;
            if (skid_full) begin
                skid_pop = 1'b1;
                ifid_d   = make_if_id(1'b1, skid_pc, skid_instr, 1'b0);
            end else if (resp_valid_q) begin
                ifid_d = make_if_id(1'b1, resp_pc_q, imem_rdata, 1'b0);
            end else begin
                ifid_d = if_id_bubble();
            end
            resp_valid_d = 1'b1;
            resp_pc_d    = pc_q;
            pc_d         = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= BOOT;
            pc_q         <= pc_init;
            resp_valid_q <= 1'b0;
            resp_pc_q    <= '0;
            ifid_q       <= if_id_bubble();
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            resp_valid_q <= resp_valid_d;
            resp_pc_q    <= resp_pc_d;
            ifid_q       <= ifid_d;
        end
    end

    rvp_fetch_skid u_skid (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (skid_push),
        .pop_i   (skid_pop),
        .flush_i (skid_flush),
        .pc_i    (resp_pc_q),
        .instr_i (imem_rdata),
        .full_o  (skid_full),
        .pc_o    (skid_pc),
        .instr_o (skid_instr)
    );

    assign imem_addr   = pc_q;
    assign if_valid    = ifid_q.valid;
    assign if_pc       = ifid_q.pc;
    assign if_instr    = ifid_q.instr;
    assign if_misalign = ifid_q.misalign;

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// Self-checking bench for riscv_fetch_stage: directed scenarios followed by
// randomized stall/redirect traffic, checked against a queue-based fetch model.
module tb_riscv_fetch_stage;

    localparam logic [31:0] Nop = 32'h0000_0013;
`ifdef RVP_FETCH_MISALIGN_EN
    localparam bit MisEn = 1'b1;
`else
    localparam bit MisEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc_init = '0;
    logic        stall = 1'b0;
    logic        redirect_e = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_misalign;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    riscv_fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .pc_init     (pc_init),
        .stall       (stall),
        .redirect_e  (redirect_e),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
        .if_misalign (if_misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Synchronous instruction memory, 1-cycle latency.
    always @(posedge clk) imem_rdata <= mem_word(imem_addr);

    // ---------------- reference model ----------------
    logic [31:0] m_pc;        // address the stage is presenting to imem
    logic [31:0] m_fpc;       // address whose read was launched last cycle
    bit          m_fetched;
    bit          m_halt;
    logic [31:0] pend[$];     // instructions returned but not yet delivered
    bit          o_valid, o_mis;
    logic [31:0] o_pc, o_instr;

    task automatic model_reset(input logic [31:0] pc0);
        m_pc = pc0; m_fpc = '0; m_fetched = 0; m_halt = 0;
        pend.delete();
        o_valid = 0; o_pc = '0; o_instr = Nop; o_mis = 0;
    endtask

    task automatic model_step(input bit st, input bit rd, input logic [31:0] rpc);
        logic [31:0] t, p;
        if (rd) begin
            t = MisEn ? rpc : {rpc[31:2], 2'b00};
            pend.delete();
            m_fetched = 0;
            m_pc = t;
            if (t[1:0] != 2'b00) begin
                m_halt = 1; o_valid = 1; o_pc = t; o_instr = Nop; o_mis = 1;
            end else begin
                m_halt = 0; o_valid = 0; o_instr = Nop; o_mis = 0;
            end
        end else if (m_halt) begin
            // frozen
        end else if (st) begin
            if (m_fetched) pend.push_back(m_fpc);
            m_fetched = 0;
        end else begin
            if (m_fetched) pend.push_back(m_fpc);
            if (pend.size() != 0) begin
                p = pend.pop_front();
                o_valid = 1; o_pc = p; o_instr = mem_word(p); o_mis = 0;
            end else begin
                o_valid = 0; o_instr = Nop; o_mis = 0;
            end
            m_fpc = m_pc; m_fetched = 1; m_pc = m_pc + 32'd4;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_eq("imem_addr", imem_addr, m_pc);
        check_eq("if_valid", 32'(if_valid), 32'(o_valid));
        if (o_valid) check_eq("if_pc", if_pc, o_pc);
        check_eq("if_instr", if_instr, o_instr);
        check_eq("if_misalign", 32'(if_misalign), 32'(o_mis));
    endtask

    task automatic step(input bit st, input bit rd, input logic [31:0] rpc);
        stall = st; redirect_e = rd; redirect_pc = rpc;
        model_step(st, rd, rpc);
        @(posedge clk); #1;
        check_outputs();
    endtask

    task automatic do_reset(input logic [31:0] pc0);
        reset = 1'b0; pc_init = pc0; stall = 0; redirect_e = 0; redirect_pc = '0;
        model_reset(pc0);
        @(posedge clk); #1;
        check_outputs();
        check_eq("rst_valid", 32'(if_valid), 32'd0);
        check_eq("rst_pc", if_pc, 32'd0);
        check_eq("rst_instr", if_instr, Nop);
        check_eq("rst_addr", imem_addr, pc0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] rpc;
        bit          st, rd;

        // 1: boot latency
        do_reset(32'h0);
        step(0, 0, 0);
        step(0, 0, 0);
        check_eq("t1_valid", 32'(if_valid), 32'd1);
        check_eq("t1_pc", if_pc, 32'h0);
        check_eq("t1_instr", if_instr, 32'hDEAD_BEEF);

        // 2: free run, no gaps
        for (int i = 1; i <= 3; i++) begin
            step(0, 0, 0);
            check_eq("t2_pc", if_pc, 32'(i * 4));
        end

        // 3: stall three cycles with if_pc = C
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0);
            check_eq("t3_hold", if_pc, 32'hC);
        end
        step(0, 0, 0);
        check_eq("t3_rel1", if_pc, 32'h10);
        step(0, 0, 0);
        check_eq("t3_rel2", if_pc, 32'h14);

        // 4: redirect
        step(0, 1, 32'h40);
        check_eq("t4_bubble_v", 32'(if_valid), 32'd0);
        check_eq("t4_bubble_i", if_instr, Nop);
        step(0, 0, 0);
        step(0, 0, 0);
        check_eq("t4_tgt", if_pc, 32'h40);
        check_eq("t4_tgt_v", 32'(if_valid), 32'd1);

        // 5: redirect beats stall
        step(1, 1, 32'h100);
        check_eq("t5_bubble_v", 32'(if_valid), 32'd0);
        step(0, 0, 0);
        step(0, 0, 0);
        check_eq("t5_tgt", if_pc, 32'h100);

        // 6: misaligned target
        step(0, 1, 32'h42);
`ifdef RVP_FETCH_MISALIGN_EN
        check_eq("t6_mis", 32'(if_misalign), 32'd1);
        check_eq("t6_pc", if_pc, 32'h42);
        step(1, 0, 0);
        step(0, 0, 0);
        check_eq("t6_hold", 32'(if_misalign), 32'd1);
        check_eq("t6_addr", imem_addr, 32'h42);
        step(0, 1, 32'h80);
        check_eq("t6_clr", 32'(if_misalign), 32'd0);
        step(0, 0, 0);
        step(0, 0, 0);
        check_eq("t6_resume", if_pc, 32'h80);
`else
        check_eq("t6_mis0", 32'(if_misalign), 32'd0);
        step(0, 0, 0);
        step(0, 0, 0);
        check_eq("t6_align", if_pc, 32'h40);
`endif

        // Redirect during BOOT squashes the pc_init fetch
        do_reset(32'hFFFF_FFF0);
        step(0, 1, 32'h200);
        step(0, 0, 0);
        step(0, 0, 0);
        check_eq("boot_redir", if_pc, 32'h200);

        // PC wrap from top of address space
        do_reset(32'hFFFF_FFF0);
        for (int i = 0; i < 8; i++) step(0, 0, 0);

        // Randomized traffic
        do_reset(32'h0000_1000);
        for (int i = 0; i < 400; i++) begin
            st = ($urandom_range(0, 99) < 30);
            rd = ($urandom_range(0, 99) < 10);
            if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF8;
            else rpc = 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            step(st, rd, rpc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
